pipe_mac_ltssm_lane: RTL and testbench

//  MAC-side, single-lane link-training initiator that drives the PIPE interface toward the PHY model.

---
 rtl/ozdefs.sv | 46 ++++
 rtl/ts_os_detector.sv | 73 +++++++
 rtl/pipe_mac_ltssm_lane.sv | 170 +++++++++++++++++
 tb/tb_pipe_mac_ltssm_lane.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ozdefs.sv
// rtl/ozdefs.sv - shared LTSSM state/OS enums, symbol constants and the TS ordered-set symbol helper
package ozdefs;

    typedef enum logic [3:0] {
        DETECT_QUIET   = 4'd0,
        DETECT_ACTIVE  = 4'd1,
        POLLING_ACTIVE = 4'd2,
        POLLING_CONFIG = 4'd3,
        CFG_LW_START   = 4'd4,
        CFG_LW_ACCEPT  = 4'd5,
        CFG_COMPLETE   = 4'd6,
        CFG_IDLE       = 4'd7,
        L0             = 4'd8
    } mac_ltssm_e;

    typedef enum logic [1:0] {OS_NONE, OS_TS1, OS_TS2, OS_IDLE} os_type_e;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [7:0] N_FTS  = 8'hFF;
    localparam logic [7:0] RATE   = 8'h02;

    // Returns {K, data} for symbol idx of the ordered set that state st transmits.
    function automatic logic [8:0] os_symbol(input mac_ltssm_e st, input logic [3:0] idx,
                                             input logic [7:0] lnk, input logic [7:0] ln);
        logic ts2, pad_link, pad_lane;
        logic [8:0] s;
        ts2      = (st == POLLING_CONFIG) || (st == CFG_COMPLETE);
        pad_link = (st == POLLING_ACTIVE) || (st == POLLING_CONFIG);
        pad_lane = pad_link || (st == CFG_LW_START);
        case (idx)
            4'd0:    s = {1'b1, COM};
            4'd1:    s = pad_link ? {1'b1, PAD} : {1'b0, lnk};
            4'd2:    s = pad_lane ? {1'b1, PAD} : {1'b0, ln};
            4'd3:    s = {1'b0, N_FTS};
            4'd4:    s = {1'b0, RATE};
            4'd5:    s = 9'h000;
            default: s = {1'b0, ts2 ? TS2_ID : TS1_ID};
        endcase
        if (st == CFG_IDLE || st == L0) s = 9'h000;
        return s;
    endfunction

endpackage

// File: rtl/ts_os_detector.sv
// rtl/ts_os_detector.sv - receive-side TS1/TS2/idle parser aligned on COM
module ts_os_detector import ozdefs::*; (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxvalid,
    input  logic [7:0] rxdata,
    input  logic       rxdatak,
    output logic       os_done,
    output os_type_e   os_type,
    output logic [7:0] os_link,
    output logic [7:0] os_lane
);
    logic       in_os;
    logic       id_ok;
    logic [3:0] idx;
    logic [7:0] id_sym;
    logic [7:0] link_r;
    logic [7:0] lane_r;
    logic       is_com;

    assign is_com = rxvalid && rxdatak && (rxdata == COM);

    // An os_done with OS_NONE tells the MAC that the consecutive-match run is broken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_os   <= 1'b0;
            id_ok   <= 1'b0;
            idx     <= 4'd0;
            id_sym  <= 8'h00;
            link_r  <= 8'h00;
            lane_r  <= 8'h00;
            os_done <= 1'b0;
            os_type <= OS_NONE;
            os_link <= 8'h00;
            os_lane <= 8'h00;
        end else begin
            os_done <= 1'b0;
            os_type <= OS_NONE;
            if (!rxvalid) begin
                if (in_os) os_done <= 1'b1;
                in_os <= 1'b0;
            end else if (is_com) begin
                if (in_os) os_done <= 1'b1;
                in_os <= 1'b1;
                idx   <= 4'd1;
                id_ok <= 1'b1;
            end else if (in_os) begin
                idx <= idx + 4'd1;
                case (idx)
                    4'd1:    link_r <= rxdata;
                    4'd2:    lane_r <= rxdata;
                    4'd6:    id_sym <= rxdata;
                    default: ;
                endcase
                if (idx >= 4'd6 && (rxdatak || (idx != 4'd6 && rxdata != id_sym)))
                    id_ok <= 1'b0;
                if (idx == 4'd15) begin
                    in_os   <= 1'b0;
                    os_done <= 1'b1;
                    os_link <= link_r;
                    os_lane <= lane_r;
                    if (id_ok && !rxdatak && rxdata == id_sym) begin
                        if (id_sym == TS1_ID)      os_type <= OS_TS1;
                        else if (id_sym == TS2_ID) os_type <= OS_TS2;
                    end
                end
            end else begin
                os_done <= 1'b1;
                os_type <= (!rxdatak && rxdata == 8'h00) ? OS_IDLE : OS_NONE;
            end
        end
    end
endmodule

// File: rtl/pipe_mac_ltssm_lane.sv
// rtl/pipe_mac_ltssm_lane.sv - single-lane PIPE MAC LTSSM initiator; LTSSM_TIMEOUT_EN enables per-state timeout
module pipe_mac_ltssm_lane import ozdefs::*; #(
    parameter int QUIET_CYC   = 16,
    parameter int N_TX_MIN    = 16,
    parameter int N_RX_MATCH  = 8,
    parameter int N_IDLE      = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] link_num,
    input  logic [7:0] lane_num,
    input  logic       phystatus,
    input  logic [2:0] rxstatus,
    input  logic       rxelecidle,
    input  logic       rxvalid,
    input  logic [7:0] rxdata,
    input  logic       rxdatak,
    output logic       txdetectrx,
    output logic [2:0] powerdown,
    output logic       txelecidle,
    output logic [7:0] txdata,
    output logic       txdatak,
    output logic [3:0] ltssm_state,
    output logic       link_up
);
    localparam int             CW         = $clog2(TIMEOUT_CYC + QUIET_CYC + 1);
    localparam logic [CW-1:0]  QUIET_LAST = CW'(QUIET_CYC - 1);
    localparam logic [7:0]     TX_MIN8    = 8'(N_TX_MIN);
    localparam logic [7:0]     RX_MATCH8  = 8'(N_RX_MATCH);
    localparam logic [7:0]     IDLE8      = 8'(N_IDLE);

    mac_ltssm_e    state, nxt_state;
    logic [3:0]    sym_cnt;
    logic [7:0]    tx_cnt, rx_match, tx_cnt_nxt, rx_match_nxt;
    logic [7:0]    link_q, lane_q;
    logic [CW-1:0] cyc_cnt;
    logic          os_done, rx_hit, training, boundary, exit_ok, go_quiet, tmo_fire;
    os_type_e      os_type;
    logic [7:0]    os_link, os_lane;
    logic [8:0]    tx_sym;

    assign ltssm_state = state;

    ts_os_detector u_det (
        .clk     (clk),
        .reset_n (reset_n),
        .rxvalid (rxvalid),
        .rxdata  (rxdata),
        .rxdatak (rxdatak),
        .os_done (os_done),
        .os_type (os_type),
        .os_link (os_link),
        .os_lane (os_lane)
    );

    always_comb begin
        rx_hit    = 1'b0;
        training  = 1'b1;
        nxt_state = state;
        case (state)
            POLLING_ACTIVE: begin rx_hit = (os_type == OS_TS1) || (os_type == OS_TS2); nxt_state = POLLING_CONFIG; end
            POLLING_CONFIG: begin rx_hit = (os_type == OS_TS2); nxt_state = CFG_LW_START; end
            CFG_LW_START:   begin rx_hit = (os_type == OS_TS1) && os_link == link_q; nxt_state = CFG_LW_ACCEPT; end
            CFG_LW_ACCEPT:  begin rx_hit = (os_type == OS_TS1) && os_link == link_q && os_lane == lane_q; nxt_state = CFG_COMPLETE; end
            CFG_COMPLETE:   begin rx_hit = (os_type == OS_TS2) && os_link == link_q && os_lane == lane_q; nxt_state = CFG_IDLE; end
            CFG_IDLE:       begin rx_hit = (os_type == OS_IDLE); nxt_state = L0; end
            default:        training = 1'b0;
        endcase
        boundary = (sym_cnt == 4'd15);
        if (!os_done)                rx_match_nxt = rx_match;
        else if (!rx_hit)            rx_match_nxt = 8'h00;
        else if (rx_match == 8'hFF)  rx_match_nxt = 8'hFF;
        else                         rx_match_nxt = rx_match + 8'd1;
        // Idles are counted per symbol, training sets per completed ordered set.
        if ((state == CFG_IDLE || boundary) && tx_cnt != 8'hFF) tx_cnt_nxt = tx_cnt + 8'd1;
        else                                                    tx_cnt_nxt = tx_cnt;
        if (state == CFG_IDLE) exit_ok = boundary && tx_cnt_nxt >= IDLE8 && rx_match_nxt >= IDLE8;
        else                   exit_ok = boundary && training && tx_cnt_nxt >= TX_MIN8 && rx_match_nxt >= RX_MATCH8;
        tx_sym = os_symbol(exit_ok ? nxt_state : state, 4'(sym_cnt + 4'd1), link_q, lane_q);
    end

`ifdef LTSSM_TIMEOUT_EN
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);
    assign tmo_fire = training && state != L0 || state == DETECT_ACTIVE
                      ? (cyc_cnt >= TMO) && (state == DETECT_ACTIVE || boundary) : 1'b0;
`else
    assign tmo_fire = 1'b0;
`endif
    assign go_quiet = tmo_fire || (state == L0 && rxelecidle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= DETECT_QUIET;
            txdetectrx <= 1'b0;
            powerdown  <= 3'd2;
            txelecidle <= 1'b1;
            txdata     <= 8'h00;
            txdatak    <= 1'b0;
            link_up    <= 1'b0;
            sym_cnt    <= 4'd0;
            tx_cnt     <= 8'h00;
            rx_match   <= 8'h00;
            cyc_cnt    <= '0;
            link_q     <= 8'h00;
            lane_q     <= 8'h00;
        end else begin
            if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
            if (go_quiet) begin
                state      <= DETECT_QUIET;
                txdetectrx <= 1'b0;
                powerdown  <= 3'd2;
                txelecidle <= 1'b1;
                txdata     <= 8'h00;
                txdatak    <= 1'b0;
                link_up    <= 1'b0;
                sym_cnt    <= 4'd0;
                tx_cnt     <= 8'h00;
                rx_match   <= 8'h00;
                cyc_cnt    <= '0;
            end else begin
                case (state)
                    DETECT_QUIET: if (cyc_cnt == QUIET_LAST) begin
                        txdetectrx <= 1'b1;
                        state      <= DETECT_ACTIVE;
                        cyc_cnt    <= '0;
                    end
                    DETECT_ACTIVE: if (phystatus) begin
                        txdetectrx <= 1'b0;
                        cyc_cnt    <= '0;
                        if (rxstatus == 3'd3) begin
                            state      <= POLLING_ACTIVE;
                            powerdown  <= 3'd0;
                            txelecidle <= 1'b0;
                            sym_cnt    <= 4'd0;
                            tx_cnt     <= 8'h00;
                            rx_match   <= 8'h00;
                            txdata     <= COM;
                            txdatak    <= 1'b1;
                        end else begin
                            state <= DETECT_QUIET;
                        end
                    end
                    L0: begin
                        sym_cnt <= sym_cnt + 4'd1;
                        txdata  <= 8'h00;
                        txdatak <= 1'b0;
                    end
                    default: begin
                        sym_cnt            <= sym_cnt + 4'd1;
                        {txdatak, txdata}  <= tx_sym;
                        tx_cnt             <= tx_cnt_nxt;
                        rx_match           <= rx_match_nxt;
                        if (exit_ok) begin
                            state    <= nxt_state;
                            tx_cnt   <= 8'h00;
                            rx_match <= 8'h00;
                            cyc_cnt  <= '0;
                            if (nxt_state == CFG_LW_START) begin
                                link_q <= link_num;
                                lane_q <= lane_num;
                            end
                            if (nxt_state == L0) link_up <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_mac_ltssm_lane.sv
// tb/tb_pipe_mac_ltssm_lane.sv - directed self-checking bench for pipe_mac_ltssm_lane
module tb_pipe_mac_ltssm_lane;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] link_num = 8'h05;
    logic [7:0] lane_num = 8'h03;
    logic       phystatus = 1'b0;
    logic [2:0] rxstatus = 3'd0;
    logic       rxelecidle = 1'b0;
    logic       rxvalid = 1'b0;
    logic [7:0] rxdata = 8'h00;
    logic       rxdatak = 1'b0;
    logic       txdetectrx, txelecidle, txdatak, link_up;
    logic [2:0] powerdown;
    logic [7:0] txdata;
    logic [3:0] ltssm_state;

    int         vectors = 0;
    int         errors = 0;
    int         elapsed = 0;
    int         n;
    logic [8:0] tx_log [16];

    always #5 clk = ~clk;

    pipe_mac_ltssm_lane #(.TIMEOUT_CYC(256)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .link_num    (link_num),
        .lane_num    (lane_num),
        .phystatus   (phystatus),
        .rxstatus    (rxstatus),
        .rxelecidle  (rxelecidle),
        .rxvalid     (rxvalid),
        .rxdata      (rxdata),
        .rxdatak     (rxdatak),
        .txdetectrx  (txdetectrx),
        .powerdown   (powerdown),
        .txelecidle  (txelecidle),
        .txdata      (txdata),
        .txdatak     (txdatak),
        .ltssm_state (ltssm_state),
        .link_up     (link_up)
    );

    task automatic tick;
        if (elapsed < 16) tx_log[elapsed] = {txdatak, txdata};
        @(negedge clk);
        elapsed++;
    endtask

    task automatic send_os(input logic [7:0] id, input logic [8:0] lnk, input logic [8:0] ln);
        logic [8:0] s;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       s = 9'h1BC;
                1:       s = lnk;
                2:       s = ln;
                3:       s = 9'h0FF;
                4:       s = 9'h002;
                5:       s = 9'h000;
                default: s = {1'b0, id};
            endcase
            rxvalid = 1'b1;
            {rxdatak, rxdata} = s;
            tick();
        end
    endtask

    task automatic send_gap(input int cycles);
        rxvalid = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic wait_exit(input logic [3:0] st);
        rxvalid = 1'b0;
        while (ltssm_state == st && elapsed < 2000) tick();
    endtask

    task automatic wait_detect;
        n = 0;
        while (!txdetectrx && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({txdetectrx, powerdown, txelecidle, txdata, txdatak, link_up, ltssm_state} !== {1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", {txdetectrx, powerdown, txelecidle, txdata, txdatak, link_up, ltssm_state}, {1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_detect_fail;
        wait_detect();
        vectors++; if (n !== 16) begin errors++; $display("FAIL quiet_cycles: got %0d expected 16", n); end
        vectors++; if (ltssm_state !== 4'd1) begin errors++; $display("FAIL detect_active: got %0d expected 1", ltssm_state); end
        phystatus = 1'b1; rxstatus = 3'd0;
        @(negedge clk);
        phystatus = 1'b0;
        vectors++; if ({ltssm_state, txdetectrx} !== {4'd0, 1'b0}) begin errors++; $display("FAIL detect_none: got %h expected 0", {ltssm_state, txdetectrx}); end
        wait_detect();
        vectors++; if (n !== 16) begin errors++; $display("FAIL redetect_cycles: got %0d expected 16", n); end
    endtask

    task automatic test_detect_ok;
        phystatus = 1'b1; rxstatus = 3'd3;
        @(negedge clk);
        phystatus = 1'b0; rxstatus = 3'd0;
        elapsed = 0;
        vectors++;
        if ({ltssm_state, powerdown, txelecidle, txdetectrx} !== {4'd2, 3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL detect_ok: got %h expected %h", {ltssm_state, powerdown, txelecidle, txdetectrx}, {4'd2, 3'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_polling;
        repeat (8) send_os(8'h4A, 9'h1F7, 9'h1F7);
        vectors++;
        if ({tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[6]} !== {9'h1BC, 9'h1F7, 9'h1F7, 9'h0FF, 9'h04A}) begin
            errors++; $display("FAIL polling_ts1_syms: got %h expected %h", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[6]}, {9'h1BC, 9'h1F7, 9'h1F7, 9'h0FF, 9'h04A});
        end
        wait_exit(4'd2);
        vectors++; if (elapsed !== 256) begin errors++; $display("FAIL polling_active_cycles: got %0d expected 256", elapsed); end
        vectors++; if (ltssm_state !== 4'd3) begin errors++; $display("FAIL polling_config: got %0d expected 3", ltssm_state); end
        elapsed = 0;
        repeat (8) send_os(8'h45, 9'h1F7, 9'h1F7);
        vectors++; if (tx_log[6] !== 9'h045) begin errors++; $display("FAIL polling_ts2_id: got %h expected 045", tx_log[6]); end
        wait_exit(4'd3);
        vectors++; if (elapsed !== 256) begin errors++; $display("FAIL polling_config_cycles: got %0d expected 256", elapsed); end
        vectors++; if (ltssm_state !== 4'd4) begin errors++; $display("FAIL cfg_lw_start: got %0d expected 4", ltssm_state); end
        elapsed = 0;
    endtask

    task automatic test_lw_start;
        link_num = 8'h09; lane_num = 8'h07;
        send_gap(112);
        vectors++; if ({tx_log[1], tx_log[2]} !== {9'h005, 9'h1F7}) begin errors++; $display("FAIL lw_start_link: got %h expected %h", {tx_log[1], tx_log[2]}, {9'h005, 9'h1F7}); end
        repeat (8) send_os(8'h4A, 9'h005, 9'h1F7);
        wait_exit(4'd4);
        vectors++; if (elapsed !== 256) begin errors++; $display("FAIL lw_start_cycles: got %0d expected 256", elapsed); end
        vectors++; if (ltssm_state !== 4'd5) begin errors++; $display("FAIL cfg_lw_accept: got %0d expected 5", ltssm_state); end
        elapsed = 0;
    endtask

    task automatic test_lane_mismatch;
        send_gap(112);
        vectors++; if ({tx_log[1], tx_log[2]} !== {9'h005, 9'h003}) begin errors++; $display("FAIL lw_accept_syms: got %h expected %h", {tx_log[1], tx_log[2]}, {9'h005, 9'h003}); end
        repeat (6) send_os(8'h4A, 9'h005, 9'h003);
        send_os(8'h4A, 9'h005, 9'h004);
        repeat (8) send_os(8'h4A, 9'h005, 9'h003);
        wait_exit(4'd5);
        vectors++; if (elapsed !== 368) begin errors++; $display("FAIL lane_mismatch_cycles: got %0d expected 368", elapsed); end
        vectors++; if (ltssm_state !== 4'd6) begin errors++; $display("FAIL cfg_complete: got %0d expected 6", ltssm_state); end
        elapsed = 0;
    endtask

    task automatic test_complete_idle;
        repeat (8) send_os(8'h45, 9'h005, 9'h003);
        vectors++; if ({tx_log[0], tx_log[2], tx_log[15]} !== {9'h1BC, 9'h003, 9'h045}) begin errors++; $display("FAIL complete_syms: got %h expected %h", {tx_log[0], tx_log[2], tx_log[15]}, {9'h1BC, 9'h003, 9'h045}); end
        wait_exit(4'd6);
        vectors++; if (elapsed !== 256) begin errors++; $display("FAIL complete_cycles: got %0d expected 256", elapsed); end
        vectors++; if (ltssm_state !== 4'd7) begin errors++; $display("FAIL cfg_idle: got %0d expected 7", ltssm_state); end
        elapsed = 0;
        rxvalid = 1'b1; rxdatak = 1'b0; rxdata = 8'h00;
        repeat (16) tick();
        vectors++; if ({tx_log[0], tx_log[9]} !== 18'h0) begin errors++; $display("FAIL idle_syms: got %h expected 0", {tx_log[0], tx_log[9]}); end
        wait_exit(4'd7);
        vectors++; if (elapsed !== 32) begin errors++; $display("FAIL idle_cycles: got %0d expected 32", elapsed); end
        vectors++; if ({ltssm_state, link_up} !== {4'd8, 1'b1}) begin errors++; $display("FAIL l0_link_up: got %h expected %h", {ltssm_state, link_up}, {4'd8, 1'b1}); end
    endtask

    task automatic test_l0_exit;
        repeat (3) @(negedge clk);
        vectors++; if ({powerdown, txelecidle, txdata} !== {3'd0, 1'b0, 8'h00}) begin errors++; $display("FAIL l0_tx: got %h expected 0", {powerdown, txelecidle, txdata}); end
        rxelecidle = 1'b1;
        @(negedge clk);
        rxelecidle = 1'b0;
        vectors++;
        if ({ltssm_state, txelecidle, powerdown, link_up} !== {4'd0, 1'b1, 3'd2, 1'b0}) begin
            errors++; $display("FAIL l0_exit: got %h expected %h", {ltssm_state, txelecidle, powerdown, link_up}, {4'd0, 1'b1, 3'd2, 1'b0});
        end
    endtask

    task automatic test_reset_mid_ts;
        wait_detect();
        vectors++; if (txdetectrx !== 1'b1) begin errors++; $display("FAIL mid_detect: got %b expected 1", txdetectrx); end
        phystatus = 1'b1; rxstatus = 3'd3;
        @(negedge clk);
        phystatus = 1'b0; rxstatus = 3'd0;
        repeat (5) @(negedge clk);
        vectors++; if ({ltssm_state, txdata} !== {4'd2, 8'h00}) begin errors++; $display("FAIL mid_ts_sym: got %h expected %h", {ltssm_state, txdata}, {4'd2, 8'h00}); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({txdetectrx, powerdown, txelecidle, txdata, txdatak, link_up, ltssm_state} !== {1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL mid_ts_reset: got %h expected %h", {txdetectrx, powerdown, txelecidle, txdata, txdatak, link_up, ltssm_state}, {1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef LTSSM_TIMEOUT_EN
    task automatic test_timeout;
        wait_detect();
        phystatus = 1'b1; rxstatus = 3'd3;
        @(negedge clk);
        phystatus = 1'b0; rxstatus = 3'd0;
        elapsed = 0;
        wait_exit(4'd2);
        vectors++; if (elapsed !== 272) begin errors++; $display("FAIL timeout_cycles: got %0d expected 272", elapsed); end
        vectors++; if ({ltssm_state, txelecidle, powerdown} !== {4'd0, 1'b1, 3'd2}) begin errors++; $display("FAIL timeout_state: got %h expected %h", {ltssm_state, txelecidle, powerdown}, {4'd0, 1'b1, 3'd2}); end
    endtask
`endif

    initial begin
        test_reset();
        test_detect_fail();
        test_detect_ok();
        test_polling();
        test_lw_start();
        test_lane_mismatch();
        test_complete_idle();
        test_l0_exit();
        test_reset_mid_ts();
`ifdef LTSSM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
